// File: rtl/mp_bank_rd_if.sv
// -----------------------------------------------------------------------------
// mp_bank_rd_if
// Bank-read and output-stream bus between the pooled-feature read sequencer
// (mp_bank_rd) and its surroundings: the four pooled-row banks on one side and
// the next convolution layer on the other.
//
// Signals:
//   rden     [3:0]      per-bank read enable          (sequencer -> banks)
//   rd_addr  [AW-1:0]   column address, all banks      (sequencer -> banks)
//   q0..q3   [3*BD-1:0] bank read data {c2,c1,c0}      (banks -> sequencer)
//   de_out              output data valid              (sequencer -> consumer)
//   row0..2  [3*BD-1:0] top/middle/bottom row samples  (sequencer -> consumer)
//   col_out  [AW-1:0]   column index of current output (sequencer -> consumer)
//
// Modports: master = sequencer side, slave = bank/consumer side.
// -----------------------------------------------------------------------------
interface mp_bank_rd_if #(
    parameter int BD = 18,
    parameter int AW = 11
);
    logic [3:0]      rden;
    logic [AW-1:0]   rd_addr;
    logic [3*BD-1:0] q0;
    logic [3*BD-1:0] q1;
    logic [3*BD-1:0] q2;
    logic [3*BD-1:0] q3;
    logic            de_out;
    logic [3*BD-1:0] row0;
    logic [3*BD-1:0] row1;
    logic [3*BD-1:0] row2;
    logic [AW-1:0]   col_out;

    modport master (
        output rden, rd_addr, de_out, row0, row1, row2, col_out,
        input  q0, q1, q2, q3
    );

    modport slave (
        input  rden, rd_addr, de_out, row0, row1, row2, col_out,
        output q0, q1, q2, q3
    );
endinterface

// File: rtl/mp_bank_rd.sv
// -----------------------------------------------------------------------------
// mp_bank_rd
// Read sequencer for the four-bank pooled-feature buffer. Rows are written one
// per bank in rotation (bank = row mod 4); this block reads three vertically
// adjacent rows per group, column by column, and presents them with a de_out
// strobe. A credit counter (0..4) tracks buffered rows so the writer is held
// off (wr_full) before it could overwrite an unconsumed row.
//
// Ports:
//   clk          clock
//   RESET        synchronous active-high reset
//   start_rd     level; arms a frame read from IDLE
//   row_wr_done  pulse; writer finished one pooled row
//   bus          mp_bank_rd_if.master: rden/rd_addr/q0..q3 bank read,
//                de_out/row0..row2/col_out output stream
//   wr_full      four rows buffered, writer must hold (credits == 4)
//   ovf          sticky; a row arrived while full and was dropped
//   fin_rd       one-cycle pulse at frame end
//
// Build option:
//   MP_RD_ZERO_PAD_EN  each group emits W+2 columns; columns 0 and W+1 are
//                      zero pads with de_out=1 and no bank read.
// -----------------------------------------------------------------------------
module mp_bank_rd #(
    parameter int BD     = 18,
    parameter int AW     = 11,
    parameter int W      = 13,
    parameter int H      = 13,
    parameter int RD_LAT = 2
) (
    input  logic         clk,
    input  logic         RESET,
    input  logic         start_rd,
    input  logic         row_wr_done,
    mp_bank_rd_if.master bus,
    output logic         wr_full,
    output logic         ovf,
    output logic         fin_rd
);

`ifdef MP_RD_ZERO_PAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif
    localparam int NCOL = W + 2 * PAD;           // columns emitted per group
    localparam int GW   = $clog2(H + 1);
    localparam int DW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_GAP,
        S_DRAIN
    } state_t;

    // Tag travelling alongside a bank read so the output stage knows which
    // bank holds the top row and which column it is presenting.
    typedef struct packed {
        logic          valid;
        logic [1:0]    base;
        logic [AW-1:0] col;
    } tag_t;

    state_t        state_q,   state_d;
    logic [2:0]    credits_q, credits_d;
    logic [1:0]    base_q,    base_d;
    logic [GW-1:0] grp_q,     grp_d;
    logic [AW-1:0] col_q,     col_d;
    logic [DW-1:0] dcnt_q,    dcnt_d;
    logic          ovf_q,     ovf_d;
    logic          fin_q,     fin_d;
    logic [3:0]    rden_q,    rden_d;
    logic [AW-1:0] addr_q,    addr_d;
    tag_t          iss_q,     iss_d;
    tag_t          dl_q [RD_LAT];

    logic          release_c;
    logic          frame_end_c;
    logic          interior_c;

    // Banks base, base+1, base+2 (mod 4): rotate 4'b0111 left by base.
    function automatic logic [3:0] bank_mask(input logic [1:0] b);
        logic [3:0] m;
        m = 4'b0111;
        return (m << b) | (m >> (3'd4 - {1'b0, b}));
    endfunction

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d starts from its _q (or a fixed default) so no path
        // through this block can leave a variable unassigned and infer a latch.
        state_d     = state_q;
        credits_d   = credits_q;
        base_d      = base_q;
        grp_d       = grp_q;
        col_d       = col_q;
        dcnt_d      = dcnt_q;
        ovf_d       = ovf_q;
        fin_d       = 1'b0;
        frame_end_c = 1'b0;
        release_c   = (state_q == S_GAP);

        // Credit bookkeeping: a coincident write and release cancel out; a
        // write while full is dropped and flagged.
        if (row_wr_done && !release_c) begin
            if (credits_q == 3'd4) begin
                ovf_d = 1'b1;
            end else begin
                credits_d = credits_q + 3'd1;
            end
        end else if (release_c && !row_wr_done) begin
            credits_d = credits_q - 3'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_rd) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (credits_q >= 3'd3) begin
                    state_d = S_READ;
                    col_d   = '0;
                end
            end
            S_READ: begin
                if (col_q == AW'(NCOL - 1)) begin
                    state_d = S_GAP;
                end else begin
                    col_d = col_q + AW'(1);
                end
            end
            S_GAP: begin
                base_d = base_q + 2'd1;
                grp_d  = grp_q + GW'(1);
                dcnt_d = '0;
                if (grp_d == GW'(H - 2)) begin
                    // The GAP cycle is the first of the RD_LAT drain cycles.
                    if (RD_LAT > 1) begin
                        state_d = S_DRAIN;
                    end else begin
                        frame_end_c = 1'b1;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == DW'(RD_LAT - 2)) begin
                    frame_end_c = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (frame_end_c) begin
            state_d   = S_IDLE;
            fin_d     = 1'b1;
            base_d    = '0;
            grp_d     = '0;
            credits_d = '0;
        end

        // Registered read-side outputs for the coming cycle. Pad columns get
        // a valid tag but no bank read.
        interior_c = (PAD == 0) || ((col_d != '0) && (col_d != AW'(NCOL - 1)));
        rden_d     = '0;
        addr_d     = '0;
        iss_d      = '0;
        if (state_d == S_READ) begin
            iss_d = '{valid: 1'b1, base: base_d, col: col_d};
            if (interior_c) begin
                rden_d = bank_mask(base_d);
                addr_d = col_d - AW'(PAD);
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            credits_q <= '0;
            base_q    <= '0;
            grp_q     <= '0;
            col_q     <= '0;
            dcnt_q    <= '0;
            ovf_q     <= 1'b0;
            fin_q     <= 1'b0;
            rden_q    <= '0;
            addr_q    <= '0;
            iss_q     <= '0;
            // NOTE: the tag delay line is reset with the control state so a
            // reset mid-frame kills any de_out already in flight.
            for (int i = 0; i < RD_LAT; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge value, so stage order in the delay line is irrelevant.
            state_q   <= state_d;
            credits_q <= credits_d;
            base_q    <= base_d;
            grp_q     <= grp_d;
            col_q     <= col_d;
            dcnt_q    <= dcnt_d;
            ovf_q     <= ovf_d;
            fin_q     <= fin_d;
            rden_q    <= rden_d;
            addr_q    <= addr_d;
            iss_q     <= iss_d;
            dl_q[0]   <= iss_q;
            for (int i = 1; i < RD_LAT; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output stage: the last delay-line tag lines up with bank data q.
    // ------------------------------------------------------------------------
    tag_t            out_c;
    logic [3*BD-1:0] q_c [4];
    logic [1:0]      b1_c;
    logic [1:0]      b2_c;
    logic            pad_c;

    assign out_c = dl_q[RD_LAT-1];
    assign q_c[0] = bus.q0;
    assign q_c[1] = bus.q1;
    assign q_c[2] = bus.q2;
    assign q_c[3] = bus.q3;

    always_comb begin
        b1_c     = out_c.base + 2'd1;
        b2_c     = out_c.base + 2'd2;
        pad_c    = (PAD != 0) && ((out_c.col == '0) || (out_c.col == AW'(NCOL - 1)));
        bus.row0 = '0;
        bus.row1 = '0;
        bus.row2 = '0;
        if (out_c.valid && !pad_c) begin
            bus.row0 = q_c[out_c.base];
            bus.row1 = q_c[b1_c];
            bus.row2 = q_c[b2_c];
        end
    end

    assign bus.de_out  = out_c.valid;
    assign bus.col_out = out_c.col;
    assign bus.rden    = rden_q;
    assign bus.rd_addr = addr_q;
    assign wr_full     = (credits_q == 3'd4);
    assign ovf         = ovf_q;
    assign fin_rd      = fin_q;

endmodule

// File: tb/tb_mp_bank_rd.sv
// -----------------------------------------------------------------------------
// tb_mp_bank_rd
// Scoreboard bench for mp_bank_rd. The stimulus process queues the expected
// bank reads and output samples for a frame; negedge monitors pop and compare
// whenever the DUT asserts rden or de_out. A small bank model returns a
// distinct pattern per (bank, address) RD_LAT cycles after a read, and a poison
// value for banks that were not enabled. Honours MP_RD_ZERO_PAD_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mp_bank_rd;
    localparam int BD     = 18;
    localparam int AW     = 11;
    localparam int W      = 13;
    localparam int H      = 13;
    localparam int RD_LAT = 2;
`ifdef MP_RD_ZERO_PAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif
    localparam int NCOL = W + 2 * PAD;
    localparam int NGRP = H - 2;

    logic clk = 1'b0;
    logic RESET;
    logic start_rd;
    logic row_wr_done;
    logic wr_full;
    logic ovf;
    logic fin_rd;

    mp_bank_rd_if #(.BD(BD), .AW(AW)) bus ();

    mp_bank_rd #(.BD(BD), .AW(AW), .W(W), .H(H), .RD_LAT(RD_LAT)) dut (
        .clk         (clk),
        .RESET       (RESET),
        .start_rd    (start_rd),
        .row_wr_done (row_wr_done),
        .bus         (bus),
        .wr_full     (wr_full),
        .ovf         (ovf),
        .fin_rd      (fin_rd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bank contents: channel k of bank b at column a = (k+1)*20000 + b*1000 + a.
    function automatic logic [3*BD-1:0] pat(input int bank, input int addr);
        logic [BD-1:0] c0, c1, c2;
        c0 = BD'(20000 + bank * 1000 + addr);
        c1 = BD'(40000 + bank * 1000 + addr);
        c2 = BD'(60000 + bank * 1000 + addr);
        return {c2, c1, c0};
    endfunction

    // Hand-computed enables for top-row bank 0..3.
    function automatic logic [3:0] mask_of(input int b);
        case (b)
            0:       return 4'b0111;
            1:       return 4'b1110;
            2:       return 4'b1101;
            default: return 4'b1011;
        endcase
    endfunction

    // ---------------- bank model ----------------
    logic [3:0]      rp [RD_LAT];
    logic [AW-1:0]   ap [RD_LAT];
    logic [3*BD-1:0] poison;
    assign poison = '1;

    always @(posedge clk) begin
        rp[0] <= bus.rden;
        ap[0] <= bus.rd_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            rp[i] <= rp[i-1];
            ap[i] <= ap[i-1];
        end
    end

    assign bus.q0 = rp[RD_LAT-1][0] ? pat(0, int'(ap[RD_LAT-1])) : poison;
    assign bus.q1 = rp[RD_LAT-1][1] ? pat(1, int'(ap[RD_LAT-1])) : poison;
    assign bus.q2 = rp[RD_LAT-1][2] ? pat(2, int'(ap[RD_LAT-1])) : poison;
    assign bus.q3 = rp[RD_LAT-1][3] ? pat(3, int'(ap[RD_LAT-1])) : poison;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [3*BD-1:0] r0;
        logic [3*BD-1:0] r1;
        logic [3*BD-1:0] r2;
        logic [AW-1:0]   col;
        bit              pad;
    } exp_out_t;

    typedef struct {
        logic [3:0]    mask;
        logic [AW-1:0] addr;
    } exp_rd_t;

    exp_out_t eq_out [$];
    exp_rd_t  eq_rd  [$];
    int       tq     [$];

    task automatic push_frame();
        for (int g = 0; g < NGRP; g++) begin
            int b;
            b = g % 4;
            for (int a = 0; a < W; a++) begin
                exp_rd_t er;
                er.mask = mask_of(b);
                er.addr = AW'(a);
                eq_rd.push_back(er);
            end
            for (int c = 0; c < NCOL; c++) begin
                exp_out_t eo;
                eo.col = AW'(c);
                eo.pad = (PAD != 0) && (c == 0 || c == NCOL - 1);
                if (eo.pad) begin
                    eo.r0 = '0;
                    eo.r1 = '0;
                    eo.r2 = '0;
                end else begin
                    eo.r0 = pat(b, c - PAD);
                    eo.r1 = pat((b + 1) % 4, c - PAD);
                    eo.r2 = pat((b + 2) % 4, c - PAD);
                end
                eq_out.push_back(eo);
            end
        end
    endtask

    bit       sb_en       = 1'b0;
    int       rden_raw    = 0;
    int       de_raw      = 0;
    int       de_cnt      = 0;
    int       fin_cnt     = 0;
    int       run         = 0;
    int       runs        = 0;
    int       last_rd_cyc = 0;
    exp_rd_t  m_rd;
    exp_out_t m_out;

    always @(negedge clk) begin
        if (bus.rden != 4'b0) rden_raw++;
        if (bus.de_out) de_raw++;
        if (sb_en) begin
            if (bus.rden != 4'b0) begin
                last_rd_cyc = cyc;
                tq.push_back(cyc + RD_LAT);
                if (eq_rd.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    m_rd = eq_rd.pop_front();
                    check("rden", bus.rden, m_rd.mask);
                    check("rd_addr", bus.rd_addr, m_rd.addr);
                end
            end
            if (bus.de_out) begin
                de_cnt++;
                run++;
                if (eq_out.size() == 0) begin
                    check("de_unexpected", 1, 0);
                end else begin
                    m_out = eq_out.pop_front();
                    check("col_out", bus.col_out, m_out.col);
                    check("row0", bus.row0, m_out.r0);
                    check("row1", bus.row1, m_out.r1);
                    check("row2", bus.row2, m_out.r2);
                    if (!m_out.pad) begin
                        if (tq.size() == 0) check("de_no_read", 1, 0);
                        else check("de_latency", cyc, tq.pop_front());
                    end
                end
            end else begin
                check("idle_rows", 64'(bus.row0 | bus.row1 | bus.row2), 0);
                if (run != 0) begin
                    check("de_run", run, NCOL);
                    runs++;
                    run = 0;
                end
            end
            // Pad columns keep READ going one cycle past the last bank read.
            if (fin_rd) begin
                fin_cnt++;
                check("fin_delay", cyc - last_rd_cyc, RD_LAT + 1 + PAD);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_row();
        row_wr_done = 1'b1;
        @(negedge clk);
        row_wr_done = 1'b0;
    endtask

    task automatic check_zero(input string p);
        check({p, "_rden"},    bus.rden,    0);
        check({p, "_rd_addr"}, bus.rd_addr, 0);
        check({p, "_de_out"},  bus.de_out,  0);
        check({p, "_row0"},    bus.row0,    0);
        check({p, "_row1"},    bus.row1,    0);
        check({p, "_row2"},    bus.row2,    0);
        check({p, "_col_out"}, bus.col_out, 0);
        check({p, "_wr_full"}, wr_full,     0);
        check({p, "_ovf"},     ovf,         0);
        check({p, "_fin_rd"},  fin_rd,      0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  rd0;
        int  d0;
        int  accepted;
        bit  found;

        RESET       = 1'b1;
        start_rd    = 1'b0;
        row_wr_done = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        RESET = 1'b0;
        @(negedge clk);
        check_zero("idle");

        // Reset in the middle of READ, with de_out in flight.
        repeat (3) pulse_row();
        start_rd = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.rden != 4'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_first_rden", found, 1);
        repeat (3) @(negedge clk);
        check("pre_rst_de_out", bus.de_out, 1);
        RESET = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        RESET = 1'b0;
        rd0 = rden_raw;
        d0  = de_raw;
        repeat (20) @(negedge clk);
        check("post_rst_no_rden", rden_raw - rd0, 0);
        check("post_rst_no_de", de_raw - d0, 0);

        start_rd = 1'b0;
        RESET    = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        @(negedge clk);
        sb_en = 1'b1;

        // Full frame: preload to full, overflow, then stream 13 rows.
        push_frame();
        repeat (4) pulse_row();
        check("full_after_4", wr_full, 1);
        check("ovf_before", ovf, 0);
        pulse_row();
        check("ovf_after_5th", ovf, 1);
        check("full_after_5th", wr_full, 1);
        start_rd = 1'b1;

        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.rden != 4'b0 && bus.rd_addr == AW'(W - 1)) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_g0_last_rden", found, 1);
        repeat (1 + PAD) @(negedge clk);
        pulse_row();
        check("gap_coincident_full", wr_full, 1);

        accepted = 5;
        for (int i = 0; i < 3000 && accepted < H; i++) begin
            if (!wr_full) begin
                pulse_row();
                accepted++;
            end else begin
                @(negedge clk);
            end
        end
        check("rows_fed", accepted, H);

        for (int i = 0; i < 3000 && fin_cnt == 0; i++) @(negedge clk);
        check("fin_seen", fin_cnt, 1);
        @(negedge clk);
        check("fin_one_cycle", fin_rd, 0);
        check("de_total", de_cnt, NGRP * NCOL);
        check("group_runs", runs, NGRP);
        check("out_queue_empty", eq_out.size(), 0);
        check("rd_queue_empty", eq_rd.size(), 0);
        check("end_wr_full", wr_full, 0);
        check("ovf_sticky", ovf, 1);

        // Credits were cleared at frame end: one new row must not start a group.
        pulse_row();
        rd0 = rden_raw;
        repeat (20) @(negedge clk);
        check("post_fin_no_rden", rden_raw - rd0, 0);
        check("post_fin_fin_cnt", fin_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
